// File: rtl/ring_counter_param_pkg.sv
// rtl/ring_counter_param_pkg.sv - mode encodings and start-state helper for ring_counter_param
package ring_counter_param_pkg;

   // Widest sequence register the start-state helper can describe.
   localparam int MAX_W = 64;

   typedef enum logic [1:0] {
      MODE_RING_L = 2'b00,
      MODE_RING_R = 2'b01,
      MODE_JOHN_L = 2'b10,
      MODE_JOHN_R = 2'b11
   } mode_e;

   // Start state of a mode: the one-hot ring seed for ring modes, all zeros
   // for Johnson modes. Callers size-cast the result down to their width.
   function automatic logic [MAX_W-1:0] start_state(input logic [1:0] mode,
                                                    input logic [MAX_W-1:0] ring_init);
      return mode[1] ? '0 : ring_init;
   endfunction

endpackage

// File: rtl/ring_counter_param_check.sv
// rtl/ring_counter_param_check.sv - combinational legality check of a sequence state
// Ports: mode  - sequence mode (ring or Johnson family)
//        count - state under test
//        legal - 1 when count belongs to the sequence family of mode
module ring_code_check
   import ring_counter_param_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] count,
   output logic             legal
);

   always_comb begin
      legal = 1'b0;
      if (mode[1]) begin
         // Johnson states are thermometer codes: at most one 0/1 boundary
         // between neighbouring bits.
         legal = ($countones(count[WIDTH-1:1] ^ count[WIDTH-2:0]) <= 1);
      end else begin
         legal = ($countones(count) == 1);
      end
   end

endmodule

// File: rtl/ring_counter_param.sv
// rtl/ring_counter_param.sv - width-generic ring / Johnson phase sequencer
// Ports: clk, rst_n     - clock, asynchronous active-low reset
//        en            - advance one step
//        init          - restart at the mode start state, clear rev_cnt
//        load/load_val - parallel load of the sequence register
//        mode          - 00 ring-left, 01 ring-right, 10 johnson-left, 11 johnson-right
//        count         - current sequence state
//        wrap          - one-cycle pulse after a step lands on the start state
//        err           - count is illegal for the current mode
//        rev_cnt       - completed revolutions, modulo 2^REV_W
module ring_counter_param
   import ring_counter_param_pkg::*;
#(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] RING_INIT    = {1'b1, {(WIDTH-1){1'b0}}},
   parameter bit               SELF_CORRECT = 1'b1,
   parameter int               REV_W        = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             init,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             err,
   output logic [REV_W-1:0] rev_cnt
);

   logic [WIDTH-1:0] s_mode;
   logic [WIDTH-1:0] next_seq;
   logic [WIDTH-1:0] count_nxt;
   logic             wrap_nxt;
   logic [REV_W-1:0] rev_nxt;
   logic             cur_legal;
   logic             nxt_legal;

   assign s_mode = WIDTH'(start_state(mode, MAX_W'(RING_INIT)));

   ring_code_check #(.WIDTH(WIDTH)) u_check_cur (
      .mode  (mode),
      .count (count),
      .legal (cur_legal)
   );

   // err is registered from the state being written, judged under the mode
   // present at this edge.
   ring_code_check #(.WIDTH(WIDTH)) u_check_nxt (
      .mode  (mode),
      .count (count_nxt),
      .legal (nxt_legal)
   );

   always_comb begin
      next_seq = count;
      case (mode)
         MODE_RING_L: next_seq = {count[WIDTH-2:0], count[WIDTH-1]};
         MODE_RING_R: next_seq = {count[0], count[WIDTH-1:1]};
         MODE_JOHN_L: next_seq = {count[WIDTH-2:0], ~count[WIDTH-1]};
         MODE_JOHN_R: next_seq = {~count[0], count[WIDTH-1:1]};
         default:     next_seq = count;
      endcase
   end

   always_comb begin
      count_nxt = count;
      wrap_nxt  = 1'b0;
      rev_nxt   = rev_cnt;
      if (init) begin
         count_nxt = s_mode;
         rev_nxt   = '0;
      end else if (load) begin
         count_nxt = load_val;
      end else if (en) begin
         if (cur_legal) begin
            count_nxt = next_seq;
            if (next_seq == s_mode) begin
               wrap_nxt = 1'b1;
               rev_nxt  = rev_cnt + REV_W'(1);
            end
         end else if (SELF_CORRECT) begin
            // Correction restarts the sequence but is not a revolution.
            count_nxt = s_mode;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= RING_INIT;
         wrap    <= 1'b0;
         err     <= 1'b0;
         rev_cnt <= '0;
      end else begin
         count   <= count_nxt;
         wrap    <= wrap_nxt;
         err     <= ~nxt_legal;
         rev_cnt <= rev_nxt;
      end
   end

endmodule

// File: tb/tb_ring_counter_param.sv
// tb/tb_ring_counter_param.sv - self-checking bench for ring_counter_param
module tb_ring_counter_param;

   logic       clk = 1'b0;
   logic       rst_n, en, init, load;
   logic [7:0] load_val;
   logic [1:0] mode;

   logic [7:0] c_a, c_b, r_a, r_b;
   logic       w_a, w_b, e_a, e_b;

   int n_checks = 0;
   int n_fail   = 0;

   // reference state: index 0 self-correcting, index 1 hold-only
   logic [7:0] m_cnt [2];
   logic [7:0] m_rev [2];
   logic       m_wrap[2];
   logic       m_err [2];

   always #5 clk = ~clk;

   ring_counter_param #(.WIDTH(8), .SELF_CORRECT(1'b1), .REV_W(8)) u_sc1 (
      .clk(clk), .rst_n(rst_n), .en(en), .init(init), .load(load),
      .load_val(load_val), .mode(mode),
      .count(c_a), .wrap(w_a), .err(e_a), .rev_cnt(r_a)
   );

   ring_counter_param #(.WIDTH(8), .SELF_CORRECT(1'b0), .REV_W(8)) u_sc0 (
      .clk(clk), .rst_n(rst_n), .en(en), .init(init), .load(load),
      .load_val(load_val), .mode(mode),
      .count(c_b), .wrap(w_b), .err(e_b), .rev_cnt(r_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // k-th state of the sequence for a mode, starting at its start state
   function automatic logic [7:0] seq_at(input logic [1:0] m, input int k);
      int v;
      case (m)
         2'b00: v = 1 << ((7 + k) % 8);
         2'b01: v = 1 << ((15 - k) % 8);
         2'b10: v = (k <= 8) ? ((1 << k) - 1) : ((255 << (k - 8)) & 255);
         default: v = (k <= 8) ? ((255 << (8 - k)) & 255) : (255 >> (k - 8));
      endcase
      return v[7:0];
   endfunction

   function automatic int period(input logic [1:0] m);
      return m[1] ? 16 : 8;
   endfunction

   // position of c within the mode's sequence, -1 when c does not belong to it
   function automatic int find_idx(input logic [1:0] m, input logic [7:0] c);
      for (int k = 0; k < period(m); k++)
         if (seq_at(m, k) == c) return k;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 8'h80; m_rev[i] = 8'h00; m_wrap[i] = 1'b0; m_err[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      logic [7:0] s;
      int         k;
      s = seq_at(mode, 0);
      for (int i = 0; i < 2; i++) begin
         m_wrap[i] = 1'b0;
         if (init) begin
            m_cnt[i] = s;
            m_rev[i] = 8'h00;
         end else if (load) begin
            m_cnt[i] = load_val;
         end else if (en) begin
            k = find_idx(mode, m_cnt[i]);
            if (k >= 0) begin
               m_cnt[i] = seq_at(mode, (k + 1) % period(mode));
               if (m_cnt[i] == s) begin
                  m_wrap[i] = 1'b1;
                  m_rev[i]  = m_rev[i] + 8'd1;
               end
            end else if (i == 0) begin
               m_cnt[i] = s;
            end
         end
         m_err[i] = (find_idx(mode, m_cnt[i]) < 0);
      end
   endtask

   task automatic compare_all();
      check("count_sc1", 32'(c_a), 32'(m_cnt[0]));
      check("wrap_sc1",  32'(w_a), 32'(m_wrap[0]));
      check("err_sc1",   32'(e_a), 32'(m_err[0]));
      check("rev_sc1",   32'(r_a), 32'(m_rev[0]));
      check("count_sc0", 32'(c_b), 32'(m_cnt[1]));
      check("wrap_sc0",  32'(w_b), 32'(m_wrap[1]));
      check("err_sc0",   32'(e_b), 32'(m_err[1]));
      check("rev_sc0",   32'(r_b), 32'(m_rev[1]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic drive(input logic i_en, input logic i_init, input logic i_load,
                        input logic [7:0] i_val, input logic [1:0] i_mode);
      en = i_en; init = i_init; load = i_load; load_val = i_val; mode = i_mode;
   endtask

   initial begin
      logic [1:0] rm;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      check("reset_count", 32'(c_a), 32'h80);
      rst_n = 1'b1;

      // ring-left full revolution
      drive(1'b0, 1'b1, 1'b0, 8'h00, 2'b00); tick();
      drive(1'b1, 1'b0, 1'b0, 8'h00, 2'b00);
      repeat (8) tick();
      check("ringl_wrap", 32'(w_a), 32'd1);
      check("ringl_rev",  32'(r_a), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 2'b00); tick();

      // johnson-right full revolution
      drive(1'b0, 1'b1, 1'b0, 8'h00, 2'b11); tick();
      check("johnr_init", 32'(c_a), 32'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 2'b11);
      repeat (9) tick();
      check("johnr_step9", 32'(c_a), 32'h7f);
      repeat (7) tick();
      check("johnr_wrap", 32'(w_a), 32'd1);
      check("johnr_rev",  32'(r_a), 32'd1);

      // illegal load: corrected in sc1, held in sc0
      drive(1'b0, 1'b0, 1'b1, 8'h06, 2'b00); tick();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 2'b00); tick();
      check("bad_load_err", 32'(e_a), 32'd1);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 2'b00); tick();
      check("corrected", 32'(c_a), 32'h80);
      check("corr_nowrap", 32'(w_a), 32'd0);
      drive(1'b0, 1'b0, 1'b1, 8'h50, 2'b10); tick();
      drive(1'b1, 1'b0, 1'b0, 8'h00, 2'b10);
      repeat (5) tick();
      check("hold_count", 32'(c_b), 32'h50);
      check("hold_err",   32'(e_b), 32'd1);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 2'b10); tick();
      check("reinit_err", 32'(e_b), 32'd0);

      // priority and direction reversal
      drive(1'b1, 1'b1, 1'b1, 8'h0f, 2'b01); tick();
      check("prio_count", 32'(c_a), 32'h80);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 2'b01);
      repeat (3) tick();
      drive(1'b1, 1'b0, 1'b0, 8'h00, 2'b00); tick();
      check("reverse", 32'(c_a), 32'h20);

      // asynchronous reset between edges
      repeat (3) tick();
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      #1;
      rst_n = 1'b1;
      repeat (4) tick();

      // randomized operation
      for (int n = 0; n < 400; n++) begin
         rm = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) != 0) rm = mode;
         if ($urandom_range(0, 1) != 0)
            load_val = seq_at(rm, $urandom_range(0, period(rm) - 1));
         else
            load_val = 8'($urandom);
         init = ($urandom_range(0, 39) == 0);
         load = ($urandom_range(0, 19) == 0);
         en   = ($urandom_range(0, 3) != 0);
         mode = rm;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ring_counter_param.md
Name: ring_counter_param

Overview:
- Parametrised successor to the fixed 8-bit ring counter.
- Width-generic shift-sequence generator with four modes: ring rotate left/right and Johnson (twisted-ring) left/right.
- Adds enable, parallel load, illegal-state detection with optional self-correction, a revolution pulse and a revolution counter.
- Used as a one-hot/Johnson phase sequencer for scanners, multiplexers and timing strobes.

Parameters:
- WIDTH, 8, sequence register width (>= 2).
- RING_INIT, {1'b1,{WIDTH-1{1'b0}}} (8'b1000_0000), start state in ring modes; must be one-hot.
- SELF_CORRECT, 1, 1 = an illegal state is replaced by the mode start state on the next enabled step; 0 = hold/flag only.
- REV_W, 8, width of the revolution counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance one step this cycle.
- init  input  1  synchronous restart to the mode start state.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  WIDTH  value loaded when load=1.
- mode  input  2  00 ring-left, 01 ring-right, 10 johnson-left, 11 johnson-right.
- count  output  WIDTH  current sequence state (registered).
- wrap  output  1  one-cycle pulse: sequence has just returned to its start state.
- err  output  1  registered; high while count holds a state illegal for the current mode.
- rev_cnt  output  REV_W  completed revolutions, modulo 2^REV_W.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count = RING_INIT.
  - wrap = 0, err = 0, rev_cnt = 0.
- Start state S(mode):
  - RING_INIT for modes 00/01.
  - All zeros for modes 10/11.
- Next-state functions:
  - ring-left: {c[W-2:0], c[W-1]}.
  - ring-right: {c[0], c[W-1:1]}.
  - johnson-left: {c[W-2:0], ~c[W-1]}.
  - johnson-right: {~c[0], c[W-1:1]}.
  - Whole-vector update only; there are no per-bit sequential overwrites.
- Priority per edge is init > load > en > hold.
  - init: count = S(mode), wrap = 0, rev_cnt = 0.
  - load: count = load_val, wrap = 0, rev_cnt unchanged.
  - en with legal state: count = next(count).
  - en with illegal state:
    - SELF_CORRECT=1: count = S(mode), wrap = 0.
    - SELF_CORRECT=0: count holds.
  - none: all state holds; wrap = 0.
- Legality:
  - Ring modes: popcount(count) == 1.
  - Johnson modes: popcount(count[W-1:1] ^ count[W-2:0]) <= 1, i.e. a thermometer code.
  - err is registered from the legality of the next count under the mode present at that edge.
  - err therefore rises the cycle after a bad load and clears the cycle after correction or re-init.
- Period: WIDTH steps in ring modes, 2*WIDTH steps in Johnson modes.
- wrap:
  - Set to 1 for exactly one cycle after an en-step (not init/load/correction) whose new count equals S(mode).
  - rev_cnt increments on the same edge and wraps from all-ones to 0.
- Mode change mid-sequence:
  - Takes effect at the next step; no implicit re-init.
  - If the current state is illegal for the new family, err asserts and the SELF_CORRECT rules apply.
  - A ring-left/ring-right swap keeps a legal state and reverses direction.
- Reset asserted mid-operation forces reset values immediately, independent of clk.
- Latency: count reflects any action one edge after the inputs are sampled.

Decomposition:
- Shared package:
  - Mode encodings MODE_RING_L, MODE_RING_R, MODE_JOHN_L, MODE_JOHN_R as 2-bit localparams/typedef.
  - Helper function returning S(mode) given WIDTH and RING_INIT.
- One combinational sub-module, ring_code_check (WIDTH, mode, count -> legal).
  - Reused by the bench scoreboard.
- Sequencing, wrap and rev_cnt stay in ring_counter_param.

Test Plan:
- Reset then init, mode=00, WIDTH=8, en=1 for 8 cycles -> count 1000_0000, 0000_0001, 0000_0010 ... 1000_0000; wrap high exactly in the cycle after the 8th step; rev_cnt=1; err=0 throughout.
- mode=11, init, en for 16 cycles -> 0000_0000, 1000_0000, 1100_0000 ... 1111_1111, 0111_1111 ... 0000_0000; wrap after step 16; rev_cnt=1.
- SELF_CORRECT=1, mode=00, load 0000_0110 -> err=1 next cycle, count held while en=0; first en -> count=1000_0000, err=0 next cycle, no wrap pulse, rev_cnt unchanged.
- SELF_CORRECT=0, mode=10, load 0101_0000 -> err stays 1 and count stays 0101_0000 across 5 enabled steps; init -> count=0000_0000, err=0.
- init, load and en all high with mode=01 -> count=RING_INIT, rev_cnt=0; then en with mode toggled 01->00 at step 3 -> direction reverses from 0001_0000 to 0010_0000, err=0.
- Assert rst_n low asynchronously between clock edges mid-sequence -> count=1000_0000, wrap=0, err=0, rev_cnt=0 before the next clk edge; sequence resumes correctly after release.
